// File: rtl/ysyx_22040088_fetch_unit_if.sv
// rtl/ysyx_22040088_fetch_unit_if.sv - fetch unit bus bundle: imem request/response, decode handshake, redirect
interface ysyx_22040088_fetch_unit_if #(
    parameter int XLEN = 64
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ysyx_22040088_fetch_unit.sv
// rtl/ysyx_22040088_fetch_unit.sv - single-outstanding instruction fetch stage with one-entry buffer
module ysyx_22040088_fetch_unit #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic                          clk,
    input  logic                          rst,
    ysyx_22040088_fetch_unit_if.master    bus
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT, S_DRAIN} state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic            req_q;
    logic            valid_q;
    logic [31:0]     inst_q;
    logic [XLEN-1:0] inst_pc_q;
    logic [XLEN-1:0] redirect_aligned;
    logic            unused_redirect_lsbs;

    assign redirect_aligned     = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = &{1'b0, bus.redirect_pc[1:0]};

    assign bus.imem_req   = req_q;
    assign bus.imem_addr  = pc;
    assign bus.inst_valid = valid_q;
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            inst_q    <= 32'h0000_0013;
            inst_pc_q <= '0;
        end else begin
            case (state)
                // S_REQ with req_q low is the one-cycle bubble after reset
                S_REQ: begin
                    if (!req_q) begin
                        req_q <= 1'b1;
                    end else if (bus.imem_gnt) begin
                        req_q <= 1'b0;
                        state <= bus.redirect_valid ? S_DRAIN : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rvalid) begin
                        if (bus.redirect_valid) begin
                            state <= S_REQ;
                            req_q <= 1'b1;
                        end else begin
                            inst_q    <= bus.imem_rdata;
                            inst_pc_q <= pc;
                            pc        <= pc + XLEN'(4);
                            valid_q   <= 1'b1;
                            state     <= S_OUT;
                        end
                    end else if (bus.redirect_valid) begin
                        state <= S_DRAIN;
                    end
                end
                S_OUT: begin
                    if (bus.redirect_valid || bus.inst_ready) begin
                        valid_q <= 1'b0;
                        state   <= S_REQ;
                        req_q   <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (bus.imem_rvalid) begin
                        state <= S_REQ;
                        req_q <= 1'b1;
                    end
                end
                default: begin
                    state <= S_REQ;
                    req_q <= 1'b1;
                end
            endcase
            // Redirect overrides any pc update made above and flushes the buffer
            if (bus.redirect_valid) begin
                pc      <= redirect_aligned;
                valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_22040088_fetch_unit.sv
// tb/tb_ysyx_22040088_fetch_unit.sv - directed and randomized bench with transaction-level fetch model
module tb_ysyx_22040088_fetch_unit;
    localparam int          XLEN     = 64;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic clk = 1'b0;
    logic rst;

    ysyx_22040088_fetch_unit_if #(.XLEN(XLEN)) bus ();

    ysyx_22040088_fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_vec   = 0;
    int n_fail  = 0;
    int n_deliv = 0;

    // Reference model: fetch pointer, outstanding beat, buffered instruction
    logic        m_known = 1'b0;
    logic        m_bubble, m_out, m_disc, m_buf_v;
    logic [31:0] m_buf_inst;
    logic [63:0] m_buf_pc, m_pc, m_addr;

    logic mem_pend = 1'b0;
    int   mem_dly  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic g, input logic rv, input logic [31:0] rd,
                        input logic rdy, input logic rdr, input logic [63:0] rpc);
        logic was_v;
        if (m_known) begin
            chk("inst_valid", 64'(bus.inst_valid), 64'(m_buf_v));
            chk("imem_req", 64'(bus.imem_req), 64'(!m_out && !m_buf_v && !m_bubble));
            if (bus.imem_req) chk("imem_addr", bus.imem_addr, m_pc);
            if (m_buf_v) begin
                chk("inst", 64'(bus.inst), 64'(m_buf_inst));
                chk("inst_pc", bus.inst_pc, m_buf_pc);
            end
        end
        rst                = r;
        bus.imem_gnt       = g;
        bus.imem_rvalid    = rv;
        bus.imem_rdata     = rd;
        bus.inst_ready     = rdy;
        bus.redirect_valid = rdr;
        bus.redirect_pc    = rpc;
        if (r) begin
            m_known  = 1'b1;
            m_bubble = 1'b1;
            m_out    = 1'b0;
            m_disc   = 1'b0;
            m_buf_v  = 1'b0;
            m_pc     = RESET_PC;
        end else begin
            was_v    = m_buf_v;
            m_bubble = 1'b0;
            if (bus.imem_req && g) begin
                m_out  = 1'b1;
                m_addr = m_pc;
                m_disc = 1'b0;
            end else if (rv && m_out) begin
                m_out = 1'b0;
                if (!m_disc && !rdr) begin
                    m_buf_v    = 1'b1;
                    m_buf_inst = rd;
                    m_buf_pc   = m_addr;
                    m_pc       = m_addr + 64'd4;
                end
            end
            if (was_v && rdy && !rdr) begin
                m_buf_v = 1'b0;
                n_deliv++;
            end
            if (rdr) begin
                m_pc    = {rpc[63:2], 2'b00};
                m_buf_v = 1'b0;
                m_disc  = m_out;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] r2;
        logic        g, rv, rdy, rdr;
        logic [31:0] rd;
        logic [63:0] rpc;

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_inst", 64'(bus.inst), 64'h13);
        chk("rst_inst_pc", bus.inst_pc, 64'h0);
        chk("rst_req", 64'(bus.imem_req), 64'h0);
        chk("rst_valid", 64'(bus.inst_valid), 64'h0);

        // Basic fetch
        step(0, 0, 0, 0, 0, 0, 0);
        chk("t1_addr", bus.imem_addr, 64'h8000_0000);
        step(0, 1, 0, 0, 1, 0, 0);
        step(0, 0, 1, 32'h0000_0093, 1, 0, 0);
        chk("t1_valid", 64'(bus.inst_valid), 64'h1);
        chk("t1_inst", 64'(bus.inst), 64'h93);
        chk("t1_inst_pc", bus.inst_pc, 64'h8000_0000);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("t1_next_addr", bus.imem_addr, 64'h8000_0004);
        chk("t1_next_req", 64'(bus.imem_req), 64'h1);

        // Backpressure
        r2 = $urandom;
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, r2, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            chk("t2_inst", 64'(bus.inst), 64'(r2));
            chk("t2_inst_pc", bus.inst_pc, 64'h8000_0004);
            chk("t2_req", 64'(bus.imem_req), 64'h0);
            step(0, 0, 0, 0, 0, 0, 0);
        end
        step(0, 0, 0, 0, 1, 0, 0);
        chk("t2_valid_drop", 64'(bus.inst_valid), 64'h0);
        chk("t2_next_addr", bus.imem_addr, 64'h8000_0008);

        // Redirect while waiting, data two cycles later
        step(0, 1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 1, 64'h8000_0103);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 32'hDEAD_BEEF, 1, 0, 0);
        chk("t3_valid", 64'(bus.inst_valid), 64'h0);
        chk("t3_addr", bus.imem_addr, 64'h8000_0100);
        chk("t3_req", 64'(bus.imem_req), 64'h1);

        // Redirect coincident with grant
        step(0, 1, 0, 0, 1, 1, 64'h8000_1000);
        chk("t4_req_drain", 64'(bus.imem_req), 64'h0);
        step(0, 0, 1, 32'h1234_5678, 1, 0, 0);
        chk("t4_valid", 64'(bus.inst_valid), 64'h0);
        chk("t4_addr", bus.imem_addr, 64'h8000_1000);

        // Redirect in output stage with ready
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h0000_0513, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 64'h8000_2000);
        chk("t5_valid", 64'(bus.inst_valid), 64'h0);
        chk("t5_addr", bus.imem_addr, 64'h8000_2000);

        // Stall then reset
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            chk("t6_stall_addr", bus.imem_addr, 64'h8000_2000);
        end
        step(1, 0, 0, 0, 0, 0, 0);
        chk("t6_rst_req", 64'(bus.imem_req), 64'h0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("t6_addr", bus.imem_addr, 64'h8000_0000);
        chk("t6_req", 64'(bus.imem_req), 64'h1);
        chk("t6_valid", 64'(bus.inst_valid), 64'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            rv = 1'b0;
            if (mem_pend) begin
                if (mem_dly == 0) begin
                    rv       = 1'b1;
                    mem_pend = 1'b0;
                end else begin
                    mem_dly--;
                end
            end
            g = ($urandom_range(0, 2) != 0);
            if (bus.imem_req && g) begin
                mem_pend = 1'b1;
                mem_dly  = $urandom_range(0, 2);
            end
            rd  = $urandom;
            rdy = 1'($urandom_range(0, 1));
            rdr = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 3) == 0)
                rpc = 64'hFFFF_FFFF_FFFF_FFF4 + 64'($urandom_range(0, 11));
            else
                rpc = {32'h0, $urandom};
            step(0, g, rv, rd, rdy, rdr, rpc);
        end
        chk("delivered", 64'(n_deliv > 20), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
